// File: rtl/timer32_pkg.sv
// Shared constants and types for the 32-bit prescaled match timer.
//   WIDTH      : width of PC, TC, PR and the match registers
//   N_MATCH    : number of match channels
//   TCR_*      : bit positions in the timer control register
//   MCR_*      : per-channel bit offsets in the match control register,
//                MCR_STRIDE bits per channel
//   ch_rsp_t   : decoded result from one match channel
package timer32_pkg;
    localparam int WIDTH      = 32;
    localparam int N_MATCH    = 4;
    localparam int TCR_EN     = 0;
    localparam int TCR_RST    = 1;
    localparam int MCR_INT    = 0;
    localparam int MCR_RST    = 1;
    localparam int MCR_STOP   = 2;
    localparam int MCR_STRIDE = 3;

    typedef struct packed {
        logic match;  // tc == mr on a prescale tick
        logic irq;    // match with interrupt enabled
        logic rst;    // match requesting TC reset
        logic stop;   // match requesting halt
    } ch_rsp_t;
endpackage

// File: rtl/timer32_match_ch.sv
// One match channel: compares TC with its match value on a prescale tick
// and decodes its three MCR bits into interrupt/reset/stop requests.
//   tick : prescale terminal count reached this clock (timer running)
//   tc   : current registered timer counter
//   mr   : match value for this channel
//   mcr  : this channel's {stop, reset, int} control bits
//   rsp  : decoded match response (combinational)
module timer32_match_ch
    import timer32_pkg::*;
(
    input  logic                  tick,
    input  logic [WIDTH-1:0]      tc,
    input  logic [WIDTH-1:0]      mr,
    input  logic [MCR_STRIDE-1:0] mcr,
    output ch_rsp_t               rsp
);
    logic hit;

    assign hit = tick && (tc == mr);

    always_comb begin
        rsp       = '0;
        rsp.match = hit;
        rsp.irq   = hit & mcr[MCR_INT];
        rsp.rst   = hit & mcr[MCR_RST];
        rsp.stop  = hit & mcr[MCR_STOP];
    end
endmodule

// File: rtl/timer_32.sv
// 32-bit prescaled timer/counter with four match channels.
// PC divides clk by pr+1; TC advances once per prescale tick. Each match
// channel can set a sticky interrupt flag, reset TC, or halt the timer.
// Ports:
//   tcr    : [0] counter enable, [1] counter reset (held), [7:2] ignored
//   pr     : prescale terminal value
//   mr0-3  : match values
//   mcr    : 3 bits per channel {stop, reset, int}; [15:12] ignored
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset
//   tc, pc : timer / prescale counters
//   ir     : sticky match interrupt flags
//   mpulse : one-cycle pulse per match event
//   em     : external match toggles (only with TIMER32_EXT_MATCH_EN)
// Build option: define TIMER32_EXT_MATCH_EN to add the em output.
module timer_32
    import timer32_pkg::*;
(
    input  logic [7:0]         tcr,
    input  logic [WIDTH-1:0]   pr,
    input  logic [WIDTH-1:0]   mr0,
    input  logic [WIDTH-1:0]   mr1,
    input  logic [WIDTH-1:0]   mr2,
    input  logic [WIDTH-1:0]   mr3,
    input  logic [15:0]        mcr,
    input  logic               clk,
    input  logic               reset,
    output logic [WIDTH-1:0]   tc,
    output logic [WIDTH-1:0]   pc,
    output logic [N_MATCH-1:0] ir,
    output logic [N_MATCH-1:0] mpulse
`ifdef TIMER32_EXT_MATCH_EN
    ,
    output logic [N_MATCH-1:0] em
`endif
);
    logic                          halt;
    logic                          run;
    logic                          tick;
    logic                          clr;
    logic [N_MATCH-1:0][WIDTH-1:0] mr_vec;
    ch_rsp_t [N_MATCH-1:0]         rsp;
    logic [N_MATCH-1:0]            hit;
    logic [N_MATCH-1:0]            irq_req;
    logic                          any_rst;
    logic                          any_stop;
    logic                          unused_bits;

    assign unused_bits = ^{tcr[7:2], mcr[15:12]};

    assign mr_vec = {mr3, mr2, mr1, mr0};
    assign clr    = reset | tcr[TCR_RST];
    assign run    = tcr[TCR_EN] & ~tcr[TCR_RST] & ~halt;
    // pc == pr only; if pr was lowered below pc, pc runs on and wraps.
    assign tick   = run && (pc == pr);

    for (genvar g = 0; g < N_MATCH; g++) begin : g_ch
        timer32_match_ch u_ch (
            .tick (tick),
            .tc   (tc),
            .mr   (mr_vec[g]),
            .mcr  (mcr[g*MCR_STRIDE +: MCR_STRIDE]),
            .rsp  (rsp[g])
        );
    end

    always_comb begin
        hit      = '0;
        irq_req  = '0;
        any_rst  = 1'b0;
        any_stop = 1'b0;
        for (int i = 0; i < N_MATCH; i++) begin
            hit[i]     = rsp[i].match;
            irq_req[i] = rsp[i].irq;
            any_rst    = any_rst  | rsp[i].rst;
            any_stop   = any_stop | rsp[i].stop;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            tc     <= '0;
            pc     <= '0;
            ir     <= '0;
            mpulse <= '0;
            halt   <= 1'b0;
        end else begin
            mpulse <= '0;
            if (run) begin
                if (tick) begin
                    pc     <= '0;
                    tc     <= any_rst ? '0 : tc + WIDTH'(1);
                    ir     <= ir | irq_req;
                    mpulse <= hit;
                    // Stop takes effect after this tick's reset/increment.
                    if (any_stop)
                        halt <= 1'b1;
                end else begin
                    pc <= pc + WIDTH'(1);
                end
            end
        end
    end

`ifdef TIMER32_EXT_MATCH_EN
    always_ff @(posedge clk) begin
        if (clr)
            em <= '0;
        else
            em <= em ^ hit;
    end
`endif
endmodule

// File: tb/tb_timer_32.sv
module tb_timer_32;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  tcr;
    logic [31:0] pr, mr0, mr1, mr2, mr3;
    logic [15:0] mcr;
    logic [31:0] tc, pc;
    logic [3:0]  ir, mpulse;
`ifdef TIMER32_EXT_MATCH_EN
    logic [3:0]  em;
`endif

    timer_32 dut (
        .tcr    (tcr),
        .pr     (pr),
        .mr0    (mr0),
        .mr1    (mr1),
        .mr2    (mr2),
        .mr3    (mr3),
        .mcr    (mcr),
        .clk    (clk),
        .reset  (reset),
        .tc     (tc),
        .pc     (pc),
        .ir     (ir),
        .mpulse (mpulse)
`ifdef TIMER32_EXT_MATCH_EN
        ,
        .em     (em)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] tc;
        logic [31:0] pc;
        logic [3:0]  ir;
        logic [3:0]  mp;
        logic [3:0]  em;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t m;
    logic m_halt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: predict the next registered state from the
    // inputs held over this clock, queue it, then compare after the edge.
    task automatic step();
        exp_t        n;
        exp_t        got;
        logic        nh;
        logic [3:0]  hit;
        logic        rq_rst, rq_stop;
        logic [31:0] mrv [4];
        mrv = '{mr0, mr1, mr2, mr3};
        n = m;
        n.mp = 4'h0;
        nh = m_halt;
        if (reset || tcr[1]) begin
            n = '0;
            nh = 1'b0;
        end else if (tcr[0] && !m_halt) begin
            if (m.pc == pr) begin
                n.pc = 32'h0;
                rq_rst = 1'b0;
                rq_stop = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    hit[i] = (m.tc == mrv[i]);
                    if (hit[i]) begin
                        if (mcr[3*i]) n.ir[i] = 1'b1;
                        rq_rst  = rq_rst  | mcr[3*i+1];
                        rq_stop = rq_stop | mcr[3*i+2];
                    end
                end
                n.tc = rq_rst ? 32'h0 : m.tc + 32'h1;
                n.mp = hit;
                n.em = m.em ^ hit;
                if (rq_stop) nh = 1'b1;
            end else begin
                n.pc = m.pc + 32'h1;
            end
        end
        sb.push_back(n);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("sb_tc", tc, got.tc);
        chk("sb_pc", pc, got.pc);
        chk("sb_ir", {28'h0, ir}, {28'h0, got.ir});
        chk("sb_mpulse", {28'h0, mpulse}, {28'h0, got.mp});
`ifdef TIMER32_EXT_MATCH_EN
        chk("sb_em", {28'h0, em}, {28'h0, got.em});
`endif
        m = got;
        m_halt = nh;
    endtask

    initial begin
        reset = 1'b1; tcr = 8'h0; pr = 32'h0; mcr = 16'h0;
        mr0 = 32'h0; mr1 = 32'h0; mr2 = 32'h0; mr3 = 32'h0;
        m = '0; m_halt = 1'b0;

        // 1: reset, then counter held in reset
        step(); step();
        chk("rst_tc", tc, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", {28'h0, ir}, 32'h0);
        chk("rst_mpulse", {28'h0, mpulse}, 32'h0);
        reset = 1'b0; tcr = 8'h02; pr = 32'd3; mr0 = 32'd3; mcr = 16'h0003;
        repeat (5) step();
        chk("hold_tc", tc, 32'h0);
        chk("hold_pc", pc, 32'h0);
        chk("hold_ir", {28'h0, ir}, 32'h0);

        // 2: prescale by 4, match ch0 resets TC and flags
        tcr = 8'h01;
        repeat (15) step();
        chk("pre_tc3", tc, 32'd3);
        chk("pre_pc3", pc, 32'd3);
        chk("pre_ir0", {28'h0, ir}, 32'h0);
        step();
        chk("m0_tc", tc, 32'h0);
        chk("m0_ir", {28'h0, ir}, 32'h1);
        chk("m0_pulse", {28'h0, mpulse}, 32'h1);
        step();
        chk("m0_pulse_end", {28'h0, mpulse}, 32'h0);
        chk("m0_ir_sticky", {28'h0, ir}, 32'h1);
        chk("m0_pc1", pc, 32'h1);
        repeat (16) step();

        // 3: stop on ch1 match
        tcr = 8'h02; pr = 32'h0; mr1 = 32'd5; mcr = 16'h0020;
        step();
        chk("clr_ir", {28'h0, ir}, 32'h0);
        tcr = 8'h01;
        repeat (6) step();
        chk("stop_tc", tc, 32'd6);
        chk("stop_pulse", {28'h0, mpulse}, 32'h2);
        repeat (3) step();
        chk("halt_tc", tc, 32'd6);
        chk("halt_pc", pc, 32'h0);
        tcr = 8'h00; step();
        tcr = 8'h01; step(); step();
        chk("halt_en_toggle", tc, 32'd6);

        // 4: counter reset clears halt
        tcr = 8'h02; step();
        chk("restart_clr", tc, 32'h0);
        tcr = 8'h01;
        repeat (3) step();
        chk("restart_tc", tc, 32'd3);

        // 5: simultaneous matches on ch0 and ch2
        tcr = 8'h02; mr0 = 32'd2; mr2 = 32'd2; mcr = 16'h0041; step();
        tcr = 8'h01;
        repeat (3) step();
        chk("dual_ir", {28'h0, ir}, 32'h5);
        chk("dual_pulse", {28'h0, mpulse}, 32'h5);
        chk("dual_tc", tc, 32'd3);
`ifdef TIMER32_EXT_MATCH_EN
        chk("dual_em", {28'h0, em}, 32'h5);
`endif
        step();
        chk("dual_tc4", tc, 32'd4);
        chk("dual_ir_sticky", {28'h0, ir}, 32'h5);

        // 6: synchronous reset mid-count
        repeat (3) step();
        reset = 1'b1; step();
        chk("midrst_tc", tc, 32'h0);
        chk("midrst_ir", {28'h0, ir}, 32'h0);
        reset = 1'b0; step();
        chk("resume_tc", tc, 32'h1);
        chk("resume_pc", pc, 32'h0);

        // 7: pr lowered below pc, pc runs past it
        tcr = 8'h02; pr = 32'd10; mcr = 16'h0; step();
        tcr = 8'h01;
        repeat (6) step();
        chk("prlow_pc6", pc, 32'd6);
        pr = 32'd2;
        repeat (3) step();
        chk("prlow_pc9", pc, 32'd9);
        chk("prlow_tc", tc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
